// File: rtl/tt_uart.sv
// Wrapper-facing alias file kept empty of logic; the transmitter top lives in tt_uart_tx.sv.
package tt_uart_build_pkg;
    localparam int TT_UART_REV = 1;
endpackage

// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the tt_uart transmitter slice.
package tt_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Total clock cycles occupied by one frame, start bit through last stop bit.
    function automatic int frame_cycles(input int cpb, input int par, input int stop);
        return (1 + DATA_BITS + par + stop) * cpb;
    endfunction

endpackage

// File: rtl/tt_uart_baud_gen.sv
// Per-bit cycle counter: counts CLKS_PER_BIT cycles and flags the last one.
module tt_uart_baud_gen #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] count;

    assign bit_done = (count == CW'(CLKS_PER_BIT - 1));

    // Count up within a bit and reload to zero at each bit boundary or on clear.
    always_ff @(posedge clk) begin
        if (rst || clear || bit_done) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/tt_uart_tx.sv
// Byte-wide valid/ready UART transmitter, LSB first, optional even parity, 1 or 2 stop bits.
module tt_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    state_t     state;
    state_t     state_next;
    logic [7:0] shift;
    logic [7:0] shift_next;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic       parity_bit;
    logic       tx_next;
    logic       bit_done;
    logic       handshake;
    logic       last_stop;

    assign handshake = tx_valid && tx_ready;
    assign last_stop = (state == STOP) && bit_done && (stop_cnt == 1'(STOP_BITS - 1));

    tt_uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (handshake || (state == IDLE)),
        .bit_done(bit_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a handshake in the final stop cycle chains straight into START.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA: begin
                if (bit_done && (bit_cnt == 3'(DATA_BITS - 1))) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY:  if (bit_done) state_next = STOP;
            STOP: begin
                if (last_stop) begin
                    state_next = handshake ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake-side outputs; ready only when idle or in the very last stop cycle.
    always_comb begin
        tx_ready = (state == IDLE) || last_stop;
        busy     = (state != IDLE);
    end

    // Next shift contents and next line level, so the pin can come straight from a flop.
    always_comb begin
        shift_next = shift;
        if (handshake) begin
            shift_next = tx_data;
        end else if ((state == DATA) && bit_done) begin
            shift_next = {1'b0, shift[7:1]};
        end
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_bit;
            default: tx_next = 1'b1;
        endcase
    end

    // Datapath registers: shift register, bit/stop counters, parity and the tx pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
        end else begin
            shift <= shift_next;
            tx    <= tx_next;
            if (handshake) begin
                parity_bit <= ^tx_data;
                bit_cnt    <= '0;
                stop_cnt   <= 1'b0;
            end else begin
                if ((state == DATA) && bit_done) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if ((state == STOP) && bit_done) begin
                    stop_cnt <= last_stop ? 1'b0 : (stop_cnt + 1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_uart_tx.sv
// Directed bench for tt_uart_tx: 8N1 and 8E1 instances at 4 clocks per bit.
module tb_tt_uart_tx;
    import tt_uart_pkg::*;

    localparam int CPB = 4;

    typedef struct {
        int          sel;
        string       name;
        logic [7:0]  data;
        logic [10:0] frame;
        int          nbits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data0 = 8'h00;
    logic       valid0 = 1'b0;
    logic       ready0, tx0, busy0;
    logic [7:0] data1 = 8'h00;
    logic       valid1 = 1'b0;
    logic       ready1, tx1, busy1;

    int total = 0;
    int bad   = 0;

    vec_t vecs[5];

    always #5 clk = ~clk;

    tt_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .tx_data(data0), .tx_valid(valid0),
        .tx_ready(ready0), .tx(tx0), .busy(busy0)
    );

    tt_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(ready1), .tx(tx1), .busy(busy1)
    );

    function automatic logic txOf(input int sel);
        return (sel != 0) ? tx1 : tx0;
    endfunction

    function automatic logic rdyOf(input int sel);
        return (sel != 0) ? ready1 : ready0;
    endfunction

    function automatic logic busyOf(input int sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input int sel, input string name);
        checkOutput($sformatf("%s tx idle d%0d", name, sel), 32'(txOf(sel)), 32'd1);
        checkOutput($sformatf("%s ready idle d%0d", name, sel), 32'(rdyOf(sel)), 32'd1);
        checkOutput($sformatf("%s busy idle d%0d", name, sel), 32'(busyOf(sel)), 32'd0);
    endtask

    // Called at a negedge; leaves the bench at the negedge of the first frame cycle.
    task automatic applyStimulus(input int sel, input logic [7:0] d, input bit hold);
        int waited = 0;
        while (rdyOf(sel) !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready before send", 32'(rdyOf(sel)), 32'd1);
        if (sel != 0) begin
            data1 = d;
            valid1 = 1'b1;
        end else begin
            data0 = d;
            valid0 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            if (sel != 0) valid1 = 1'b0;
            else valid0 = 1'b0;
        end
    endtask

    task automatic checkFrame(input int sel, input string name, input logic [10:0] frame, input int nbits);
        logic [10:0] f;
        f = frame;
        for (int i = 0; i < nbits * CPB; i++) begin
            checkOutput($sformatf("%s tx c%0d", name, i), 32'(txOf(sel)), 32'(f[i / CPB]));
            checkOutput($sformatf("%s busy c%0d", name, i), 32'(busyOf(sel)), 32'd1);
            checkOutput($sformatf("%s ready c%0d", name, i), 32'(rdyOf(sel)),
                        (i == nbits * CPB - 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Frames listed bit 0 first: start, data LSB first, [parity], stop.
        vecs[0] = '{0, "8N1 A5", 8'hA5, 11'h34A, 10};
        vecs[1] = '{0, "8N1 FF", 8'hFF, 11'h3FE, 10};
        vecs[2] = '{1, "8E1 07", 8'h07, 11'h60E, 11};
        vecs[3] = '{1, "8E1 03", 8'h03, 11'h406, 11};
        vecs[4] = '{1, "8E1 80", 8'h80, 11'h700, 11};

        rst = 1'b1;
        valid0 = 1'b1;
        valid1 = 1'b1;
        data0 = 8'h55;
        data1 = 8'h55;
        repeat (3) begin
            @(negedge clk);
            checkIdle(0, "reset");
            checkIdle(1, "reset");
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkIdle(0, "post reset");
            checkIdle(1, "post reset");
        end

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].sel, vecs[v].data, 1'b0);
            checkFrame(vecs[v].sel, vecs[v].name, vecs[v].frame, vecs[v].nbits);
            checkIdle(vecs[v].sel, vecs[v].name);
        end

        applyStimulus(0, 8'h00, 1'b1);
        data0 = 8'hFF;
        checkFrame(0, "b2b first", 11'h200, 10);
        valid0 = 1'b0;
        checkFrame(0, "b2b second", 11'h3FE, 10);
        checkIdle(0, "b2b end");

        applyStimulus(0, 8'hC3, 1'b0);
        data0 = 8'h3C;
        checkFrame(0, "stable C3", 11'h386, 10);
        checkIdle(0, "stable end");
        @(negedge clk);
        checkIdle(0, "stable quiet");

        applyStimulus(0, 8'h00, 1'b0);
        repeat (17) @(negedge clk);
        checkOutput("midframe tx before rst", 32'(tx0), 32'd0);
        checkOutput("midframe busy before rst", 32'(busy0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkIdle(0, "midframe rst");
        rst = 1'b0;
        @(negedge clk);
        checkIdle(0, "after rst");
        applyStimulus(0, 8'h5A, 1'b0);
        checkFrame(0, "after rst 5A", 11'h2B4, 10);
        checkIdle(0, "after rst end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_uart_tx.md
Name: tt_uart_tx

Overview:
- Serial transmitter that exports byte values from the user project, such as counter snapshots, onto one output pin (uo_out[0] or uio_out[n]).
- It is the driving end of the async serial link that the bench or host side receives.
- Byte-wide valid/ready input; standard 8N1/8E1/8N2 framing; LSB first.
- Sits beside the counter inside tt_um_nishit_counter on the single project clock.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per serial bit (10 MHz / 115200); legal range 2..65535.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  project clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset (the wrapper drives it from ~rst_n).
- tx_data  in  8  byte to send; sampled only at the handshake.
- tx_valid  in  1  producer has a byte.
- tx_ready  out  1  block can accept a byte this cycle.
- tx  out  1  serial line; idle high.
- busy  out  1  high while a frame is in flight.

Behaviour:
- Reset values (rst high at a clock edge, taking effect next cycle):
  - tx=1, tx_ready=1, busy=0.
  - State IDLE; bit counter and baud counter cleared.
  - rst overrides everything, including a handshake in the same cycle.
- Handshake:
  - A transfer occurs on any cycle where tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge.
  - Later changes to tx_data or tx_valid have no effect on the frame in flight.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, tx_ready=1, busy=0. On handshake go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, 8 bits, LSB first. After bit 7 go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the 8 latched bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Latency and length:
  - tx falls on the first cycle after the handshake edge (1-cycle latency).
  - Frame length is (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles exactly.
- Back-to-back frames:
  - tx_ready is also high in the final cycle of the last stop bit.
  - A handshake there starts the next START immediately, with zero idle gap.
  - Without a handshake in that cycle, the block returns to IDLE.
  - tx_ready is low in every other non-IDLE cycle.
- busy is high from the cycle after the handshake through the final stop cycle inclusive.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Reloads to 0 on every bit boundary and on handshake.
  - Never wraps mid-bit.
- Reset mid-frame: the frame is abandoned, tx=1 on the next cycle, no partial stop bit.
- tx is driven straight from a register (glitch-free pin).

Decomposition:
- Package tt_uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - DATA_BITS=8.
  - Function frame_cycles(cpb, par, stop) for benches.
- One natural sub-module, tt_uart_baud_gen:
  - Per-bit cycle counter with a clear input.
  - Outputs a bit_done pulse.
- FSM and shift register stay in tt_uart_tx.

Test Plan:
- Reset/idle: hold rst 3 cycles with tx_valid=1 -> tx=1, tx_ready=1, busy=0, no frame starts during reset.
- Single byte: CLKS_PER_BIT=4, send 0xA5 -> tx reads 0 then 1,0,1,0,0,1,0,1 then 1, each for 4 cycles. Frame is 40 cycles; busy high for exactly 40 cycles.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> second start bit begins the cycle after the first stop bit ends (no gap). Bit stream matches both bytes.
- Parity: PARITY_EN=1, send 0x07 and 0x03 -> parity bit 1 and 0 respectively. Frame is 11*CLKS_PER_BIT cycles.
- Data stability: change tx_data to 0x3C mid-frame after accepting 0xC3 -> serialized bits are still 0xC3. tx_ready stays low until the last stop cycle.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 next cycle, IDLE. A new byte 0x5A after reset transmits correctly.
